// File: rtl/pid_output_router.sv
// Routes PID results by channel into a DAC queue or per-device DDS queues and
// issues them to the output controllers over valid/ready, counting every drop.
module pid_output_router #(
   parameter int W_CHAN     = 5,
   parameter int W_DATA     = 48,
   parameter int N_DAC      = 8,
   parameter int W_DAC_CHAN = 3,
   parameter int W_DAC_DATA = 16,
   parameter int N_DDS      = 1,
   parameter int W_FREQ     = 48,
   parameter int D_DAC      = 16,
   parameter int D_DDS      = 4,
   parameter int W_CNT      = 16
) (
   input  logic                    clk_in,
   input  logic                    rst_in,
   input  logic                    dv_in,
   input  logic [W_CHAN-1:0]       chan_in,
   input  logic [W_DATA-1:0]       data_in,
   output logic                    dac_vld_out,
   input  logic                    dac_rdy_in,
   output logic [W_DAC_CHAN-1:0]   dac_chan_out,
   output logic [W_DAC_DATA-1:0]   dac_data_out,
   output logic [N_DDS-1:0]        dds_vld_out,
   input  logic [N_DDS-1:0]        dds_rdy_in,
   output logic [2*N_DDS-1:0]      dds_sel_out,
   output logic [N_DDS*W_FREQ-1:0] dds_data_out,
   input  logic                    clr_in,
   output logic [N_DDS:0]          ovf_out,
   output logic [W_CNT-1:0]        drop_cnt_out
);

   localparam int W_S1   = (W_FREQ > W_DAC_DATA) ? W_FREQ : W_DAC_DATA;
   localparam int AW_DAC = $clog2(D_DAC);
   localparam int AW_DDS = $clog2(D_DDS);

   function automatic logic [W_CNT-1:0] sat_add(input logic [W_CNT-1:0] a, input logic [1:0] b);
      logic [W_CNT+1:0] s;
      s = {2'b00, a} + {{W_CNT{1'b0}}, b};
      if (s[W_CNT+1:W_CNT] != 2'b00) return '1;
      return s[W_CNT-1:0];
   endfunction

   logic [31:0]      w_chan32;
   logic             w_dec_dac;
   logic [N_DDS-1:0] w_dec_dds;
   logic [1:0]       w_dec_sel;
   logic             w_unmap;
   logic             w_unused_data;

   assign w_chan32      = 32'(chan_in);
   assign w_unused_data = ^data_in;

   always_comb begin
      w_dec_dac = 1'b0;
      w_dec_dds = '0;
      w_dec_sel = 2'b00;
      if (w_chan32 < 32'(N_DAC)) w_dec_dac = 1'b1;
      for (int i = 0; i < N_DDS; i++) begin
         if (w_chan32 == 32'(N_DAC + i)) begin
            w_dec_dds[i] = 1'b1;
            w_dec_sel    = 2'b00;
         end
         if (w_chan32 == 32'(N_DAC + N_DDS + i)) begin
            w_dec_dds[i] = 1'b1;
            w_dec_sel    = 2'b01;
         end
         if (w_chan32 == 32'(N_DAC + 2*N_DDS + i)) begin
            w_dec_dds[i] = 1'b1;
            w_dec_sel    = 2'b10;
         end
      end
   end

   assign w_unmap = dv_in && !w_dec_dac && (w_dec_dds == '0);

   // Stage 1: decode register; unmapped results never enter it
   logic                  r_s1_dac;
   logic [N_DDS-1:0]      r_s1_dds;
   logic [1:0]            r_s1_sel;
   logic [W_DAC_CHAN-1:0] r_s1_chan;
   logic [W_S1-1:0]       r_s1_data;

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         r_s1_dac <= 1'b0;
         r_s1_dds <= '0;
      end else begin
         r_s1_dac <= dv_in && w_dec_dac;
         r_s1_dds <= dv_in ? w_dec_dds : '0;
      end
   end

   always_ff @(posedge clk_in) begin
      if (dv_in) begin
         r_s1_sel  <= w_dec_sel;
         r_s1_chan <= chan_in[W_DAC_CHAN-1:0];
         r_s1_data <= data_in[W_S1-1:0];
      end
   end

   // Stage 2: enqueue; a full queue still accepts when its head leaves this cycle
   logic [W_DAC_CHAN-1:0] r_dac_chan_mem [D_DAC];
   logic [W_DAC_DATA-1:0] r_dac_data_mem [D_DAC];
   logic [AW_DAC-1:0]     r_dac_wp, r_dac_rp;
   logic [AW_DAC:0]       r_dac_cnt;
   logic                  w_dac_pop, w_dac_full, w_dac_acc;
   logic [N_DDS:0]        w_ovf;

   assign w_dac_pop  = (r_dac_cnt != '0) && dac_rdy_in;
   assign w_dac_full = (r_dac_cnt == (AW_DAC+1)'(D_DAC));
   assign w_dac_acc  = r_s1_dac && (!w_dac_full || w_dac_pop);
   assign w_ovf[0]   = r_s1_dac && w_dac_full && !w_dac_pop;

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         r_dac_wp  <= '0;
         r_dac_rp  <= '0;
         r_dac_cnt <= '0;
      end else begin
         if (w_dac_acc) r_dac_wp <= r_dac_wp + AW_DAC'(1);
         if (w_dac_pop) r_dac_rp <= r_dac_rp + AW_DAC'(1);
         if (w_dac_acc && !w_dac_pop)      r_dac_cnt <= r_dac_cnt + (AW_DAC+1)'(1);
         else if (!w_dac_acc && w_dac_pop) r_dac_cnt <= r_dac_cnt - (AW_DAC+1)'(1);
      end
   end

   always_ff @(posedge clk_in) begin
      if (w_dac_acc) begin
         r_dac_chan_mem[r_dac_wp] <= r_s1_chan;
         r_dac_data_mem[r_dac_wp] <= r_s1_data[W_DAC_DATA-1:0];
      end
   end

   // Head outputs are gated by valid so reset forces them to zero immediately
   assign dac_vld_out  = (r_dac_cnt != '0);
   assign dac_chan_out = dac_vld_out ? r_dac_chan_mem[r_dac_rp] : '0;
   assign dac_data_out = dac_vld_out ? r_dac_data_mem[r_dac_rp] : '0;

   for (genvar g = 0; g < N_DDS; g++) begin : g_dds
      logic [1:0]        r_sel_mem [D_DDS];
      logic [W_FREQ-1:0] r_dat_mem [D_DDS];
      logic [AW_DDS-1:0] r_wp, r_rp;
      logic [AW_DDS:0]   r_cnt;
      logic              w_pop, w_full, w_acc, w_vld;

      assign w_vld      = (r_cnt != '0);
      assign w_pop      = w_vld && dds_rdy_in[g];
      assign w_full     = (r_cnt == (AW_DDS+1)'(D_DDS));
      assign w_acc      = r_s1_dds[g] && (!w_full || w_pop);
      assign w_ovf[g+1] = r_s1_dds[g] && w_full && !w_pop;

      always_ff @(posedge clk_in or negedge rst_in) begin
         if (!rst_in) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
         end else begin
            if (w_acc) r_wp <= r_wp + AW_DDS'(1);
            if (w_pop) r_rp <= r_rp + AW_DDS'(1);
            if (w_acc && !w_pop)      r_cnt <= r_cnt + (AW_DDS+1)'(1);
            else if (!w_acc && w_pop) r_cnt <= r_cnt - (AW_DDS+1)'(1);
         end
      end

      always_ff @(posedge clk_in) begin
         if (w_acc) begin
            r_sel_mem[r_wp] <= r_s1_sel;
            r_dat_mem[r_wp] <= r_s1_data[W_FREQ-1:0];
         end
      end

      assign dds_vld_out[g]                  = w_vld;
      assign dds_sel_out[2*g +: 2]           = w_vld ? r_sel_mem[r_rp] : 2'b00;
      assign dds_data_out[g*W_FREQ +: W_FREQ] = w_vld ? r_dat_mem[r_rp] : '0;
   end

   // At most one overflow per cycle since only one entry leaves stage 1
   logic [N_DDS:0]     r_ovf;
   logic [W_CNT-1:0]   r_drop;
   logic [1:0]         w_inc;

   assign w_inc = {1'b0, w_unmap} + {1'b0, |w_ovf};

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         r_ovf  <= '0;
         r_drop <= '0;
      end else if (clr_in) begin
         r_ovf  <= '0;
         r_drop <= '0;
      end else begin
         r_ovf  <= r_ovf | w_ovf;
         r_drop <= sat_add(r_drop, w_inc);
      end
   end

   assign ovf_out      = r_ovf;
   assign drop_cnt_out = r_drop;

endmodule

// File: tb/tb_pid_output_router.sv
// Bench for pid_output_router with two DDS devices and a 2-bit drop counter:
// queue-level reference model checked every cycle plus directed literal checks.
module tb_pid_output_router;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        dv = 1'b0;
   logic [4:0]  chan = '0;
   logic [47:0] data = '0;
   logic        dac_rdy = 1'b0;
   logic [1:0]  dds_rdy = 2'b00;
   logic        clr = 1'b0;

   logic        dac_vld_out;
   logic [2:0]  dac_chan_out;
   logic [15:0] dac_data_out;
   logic [1:0]  dds_vld_out;
   logic [3:0]  dds_sel_out;
   logic [95:0] dds_data_out;
   logic [2:0]  ovf_out;
   logic [1:0]  drop_cnt_out;

   always #5 clk = ~clk;

   pid_output_router #(.N_DDS(2), .W_CNT(2)) u_dut (
      .clk_in(clk), .rst_in(rst_n), .dv_in(dv), .chan_in(chan), .data_in(data),
      .dac_vld_out(dac_vld_out), .dac_rdy_in(dac_rdy), .dac_chan_out(dac_chan_out),
      .dac_data_out(dac_data_out), .dds_vld_out(dds_vld_out), .dds_rdy_in(dds_rdy),
      .dds_sel_out(dds_sel_out), .dds_data_out(dds_data_out), .clr_in(clr),
      .ovf_out(ovf_out), .drop_cnt_out(drop_cnt_out)
   );

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: one FIFO per destination, results pass through one decode cycle
   logic [18:0] q_dac[$];
   logic [49:0] q_d0[$];
   logic [49:0] q_d1[$];
   logic        pend_v = 1'b0;
   logic [1:0]  pend_dst = 2'd0;
   logic [49:0] pend_val = '0;
   int          m_drop = 0;
   logic [2:0]  m_ovf = '0;
   logic [2:0]  m_nov;
   int          m_inc, c, k;
   logic        chk_en = 1'b0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_dac.delete(); q_d0.delete(); q_d1.delete();
         pend_v = 1'b0; m_drop = 0; m_ovf = '0;
      end else begin
         m_inc = 0;
         m_nov = '0;
         if (q_dac.size() > 0 && dac_rdy)    void'(q_dac.pop_front());
         if (q_d0.size() > 0 && dds_rdy[0])  void'(q_d0.pop_front());
         if (q_d1.size() > 0 && dds_rdy[1])  void'(q_d1.pop_front());
         if (pend_v) begin
            case (pend_dst)
               2'd0: if (q_dac.size() < 16) q_dac.push_back(pend_val[18:0]);
                     else begin m_nov[0] = 1'b1; m_inc++; end
               2'd1: if (q_d0.size() < 4) q_d0.push_back(pend_val);
                     else begin m_nov[1] = 1'b1; m_inc++; end
               default: if (q_d1.size() < 4) q_d1.push_back(pend_val);
                        else begin m_nov[2] = 1'b1; m_inc++; end
            endcase
         end
         pend_v = 1'b0;
         if (dv) begin
            c = int'(chan);
            if (c < 8) begin
               pend_v = 1'b1; pend_dst = 2'd0; pend_val = {31'b0, chan[2:0], data[15:0]};
            end else if (c < 14) begin
               k = c - 8;
               pend_v = 1'b1; pend_dst = 2'(1 + k % 2); pend_val = {2'(k / 2), data};
            end else begin
               m_inc++;
            end
         end
         if (clr) begin
            m_drop = 0; m_ovf = '0;
         end else begin
            m_drop = (m_drop + m_inc > 3) ? 3 : m_drop + m_inc;
            m_ovf  = m_ovf | m_nov;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en && rst_n) begin
         chk("dac_vld", dac_vld_out, q_dac.size() != 0);
         if (q_dac.size() != 0) begin
            chk("dac_chan", dac_chan_out, q_dac[0][18:16]);
            chk("dac_data", dac_data_out, q_dac[0][15:0]);
         end
         chk("dds0_vld", dds_vld_out[0], q_d0.size() != 0);
         if (q_d0.size() != 0) begin
            chk("dds0_sel", dds_sel_out[1:0], q_d0[0][49:48]);
            chk("dds0_data", dds_data_out[47:0], q_d0[0][47:0]);
         end
         chk("dds1_vld", dds_vld_out[1], q_d1.size() != 0);
         if (q_d1.size() != 0) begin
            chk("dds1_sel", dds_sel_out[3:2], q_d1[0][49:48]);
            chk("dds1_data", dds_data_out[95:48], q_d1[0][47:0]);
         end
         chk("ovf", ovf_out, m_ovf);
         chk("drop_cnt", drop_cnt_out, 64'(m_drop));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [4:0] ch, input logic [47:0] d);
      dv = 1'b1; chan = ch; data = d;
      tick();
      dv = 1'b0;
   endtask

   initial begin
      #1 rst_n = 1'b0;
      #2;
      chk("rst_dac_vld", dac_vld_out, 1'b0);
      chk("rst_dds_vld", dds_vld_out, 2'b00);
      chk("rst_dac_data", dac_data_out, 16'h0);
      chk("rst_ovf", ovf_out, 3'b000);
      chk("rst_drop", drop_cnt_out, 2'd0);
      tick(); tick();
      rst_n = 1'b1; chk_en = 1'b1;
      tick();

      // single DAC write, rdy high
      dac_rdy = 1'b1;
      send(5'd3, 48'h00001234ABCD);
      chk("single_early_vld", dac_vld_out, 1'b0);
      tick();
      chk("single_vld", dac_vld_out, 1'b1);
      chk("single_chan", dac_chan_out, 3'd3);
      chk("single_data", dac_data_out, 16'hABCD);
      chk("single_ovf", ovf_out, 3'b000);
      tick();
      chk("single_vld_gone", dac_vld_out, 1'b0);

      // backpressure: 17 writes into a 16-deep queue
      dac_rdy = 1'b0;
      for (int i = 0; i < 17; i++) send(5'(i % 8), 48'h1000 + 48'(i));
      tick();
      chk("full_drop", drop_cnt_out, 2'd1);
      chk("full_ovf", ovf_out, 3'b001);
      chk("full_head", dac_data_out, 16'h1000);
      dac_rdy = 1'b1;
      repeat (18) tick();
      chk("drain_empty", dac_vld_out, 1'b0);
      clr = 1'b1; tick(); clr = 1'b0;
      chk("clr_ovf", ovf_out, 3'b000);
      chk("clr_drop", drop_cnt_out, 2'd0);

      // full queue with a dequeue in the enqueue cycle of the 17th entry
      dac_rdy = 1'b0;
      for (int i = 0; i < 17; i++) send(5'(i % 8), 48'h2000 + 48'(i));
      dac_rdy = 1'b1; tick(); dac_rdy = 1'b0;
      chk("simul_ovf", ovf_out, 3'b000);
      chk("simul_drop", drop_cnt_out, 2'd0);
      chk("simul_head", dac_data_out, 16'h2001);
      dac_rdy = 1'b1;
      repeat (17) tick();
      chk("simul_empty", dac_vld_out, 1'b0);

      // DDS routing with DDS1 stalled
      dds_rdy = 2'b01;
      send(5'd8,  48'hD0D0_0000_0008);
      send(5'd11, 48'hD1D1_0000_0011);
      send(5'd13, 48'hD2D2_0000_0013);
      send(5'd2,  48'h0000_0000_5A5A);
      repeat (4) tick();
      chk("dds_vld_stall", dds_vld_out, 2'b10);
      chk("dds1_head_sel", dds_sel_out[3:2], 2'b01);
      chk("dds1_head_data", dds_data_out[95:48], 48'hD1D1_0000_0011);
      chk("dds_dac_free", dac_vld_out, 1'b0);
      dds_rdy = 2'b11;
      repeat (3) tick();
      chk("dds_drained", dds_vld_out, 2'b00);

      // unmapped channel, counter saturation, clear beats increment
      repeat (5) send(5'd31, 48'hFFFF);
      tick();
      chk("unmap_drop_sat", drop_cnt_out, 2'd3);
      chk("unmap_no_dac", dac_vld_out, 1'b0);
      chk("unmap_no_dds", dds_vld_out, 2'b00);
      chk("unmap_no_ovf", ovf_out, 3'b000);
      clr = 1'b1;
      send(5'd31, 48'hFFFF);
      clr = 1'b0;
      chk("clr_prio", drop_cnt_out, 2'd0);

      // asynchronous reset with queued DAC entries
      dac_rdy = 1'b0;
      for (int i = 0; i < 5; i++) send(5'd1, 48'h7700 + 48'(i));
      repeat (2) tick();
      chk("pre_rst_vld", dac_vld_out, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_vld", dac_vld_out, 1'b0);
      chk("arst_data", dac_data_out, 16'h0);
      chk("arst_chan", dac_chan_out, 3'd0);
      tick();
      rst_n = 1'b1;
      dac_rdy = 1'b1;
      send(5'd5, 48'hFACE_0000_BEEF);
      chk("post_rst_early", dac_vld_out, 1'b0);
      tick();
      chk("post_rst_vld", dac_vld_out, 1'b1);
      chk("post_rst_chan", dac_chan_out, 3'd5);
      chk("post_rst_data", dac_data_out, 16'hBEEF);
      tick();
      chk("post_rst_empty", dac_vld_out, 1'b0);
      repeat (2) tick();

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/pid_output_router.md
Name: pid_output_router

Overview:
- Parametrised dispatcher between the PID pipeline output and the physical output controllers.
- Generalises fixed DAC/DDS routing to N_DAC DAC channels and N_DDS DDS devices.
- Decodes each PID result by channel into a DAC queue or a per-DDS queue, then issues to the controllers with a valid/ready handshake.
- Adds overflow detection, unmapped-channel drop, and drop counting.

Parameters:
- W_CHAN, 5: PID channel index width
- W_DATA, 48: PID result width; must be >= W_FREQ and >= W_DAC_DATA
- N_DAC, 8: DAC channels; occupy PID channels 0..N_DAC-1
- W_DAC_CHAN, 3: DAC channel field width
- W_DAC_DATA, 16: DAC code width
- N_DDS, 1: DDS devices
- W_FREQ, 48: DDS data field width; the full field carries frequency, phase and amplitude words
- D_DAC, 16: DAC queue depth, power of two
- D_DDS, 4: per-DDS queue depth, power of two
- W_CNT, 16: drop counter width

Ports:
- clk_in, in, 1: system clock
- rst_in, in, 1: reset, asynchronous, active-low
- dv_in, in, 1: PID result valid, single-cycle pulse
- chan_in, in, W_CHAN: PID channel
- data_in, in, W_DATA: PID result
- dac_vld_out, out, 1: DAC word valid
- dac_rdy_in, in, 1: DAC controller ready
- dac_chan_out, out, W_DAC_CHAN: DAC channel
- dac_data_out, out, W_DAC_DATA: DAC code
- dds_vld_out, out, N_DDS: per-DDS word valid
- dds_rdy_in, in, N_DDS: per-DDS ready
- dds_sel_out, out, 2*N_DDS: per-DDS selector; 00 freq, 01 phase, 10 amp
- dds_data_out, out, N_DDS*W_FREQ: per-DDS data, device i at bits [i*W_FREQ +: W_FREQ]
- clr_in, in, 1: synchronous clear of overflow flags and drop counter
- ovf_out, out, N_DDS+1: sticky overflow flags; bit 0 = DAC queue, bit i+1 = DDS i
- drop_cnt_out, out, W_CNT: saturating count of dropped results

Behaviour:
- Reset (rst_in low, asynchronous): all queues empty, decode stage invalid, every vld_out 0, every chan/sel/data output 0, ovf_out 0, drop_cnt_out 0.
- Channel map:
  - c < N_DAC -> DAC.
  - N_DAC+i -> DDS i freq.
  - N_DAC+N_DDS+i -> DDS i phase.
  - N_DAC+2*N_DDS+i -> DDS i amp.
  - Any other channel is unmapped.
- Stage 1 (decode register): on a dv_in cycle, register the destination, selector, truncated channel and low-order data bits.
  - DAC entries take data_in[W_DAC_DATA-1:0].
  - DDS entries take data_in[W_FREQ-1:0]; the controller slices phase/amp bits.
- Stage 2 (enqueue): at the edge ending the decode cycle, the entry is written into its destination queue.
  - Minimum latency: dv_in at cycle t -> vld_out high at t+2 with an empty queue. No bypass.
- Dequeue: a transfer occurs on the edge where vld && rdy.
  - The head advances.
  - vld_out stays high while the queue is non-empty.
  - Outputs are driven from the queue head and are stable while vld is high and rdy is low.
- Full queue:
  - If the queue is full and no dequeue occurs in the same cycle, the new entry is dropped. The oldest data is preserved.
  - The matching ovf_out bit sets and drop_cnt increments.
  - If a dequeue occurs in that same cycle, the entry is accepted and the count is unchanged.
- Unmapped channel: dropped at stage 1 and drop_cnt increments; no ovf bit sets.
- drop_cnt saturates at 2^W_CNT-1.
- clr_in has priority over an increment in the same cycle: the result is 0 and the flags are cleared.
- Queues are independent: a stalled DDS i never blocks the DAC queue or DDS j.
- Pointers wrap modulo depth. An explicit count register distinguishes full from empty.
- dv_in may assert on consecutive cycles; one result is accepted per cycle.
- Asserting reset mid-transfer discards all queued entries. Outputs go to 0 immediately (asynchronously).

Test Plan:
- Single DAC write: dv_in with chan=3, data=0x00001234ABCD and dac_rdy_in=1 -> dac_vld_out high for exactly 1 cycle at t+2 with chan=3, data=0xABCD; ovf_out=0.
- Backpressure and full: dac_rdy_in=0, 17 DAC writes on consecutive cycles (D_DAC=16) -> 16 queued, 17th dropped, ovf_out[0]=1, drop_cnt=1. Then rdy=1 -> 16 words emerge in order with vld held continuous.
- Full with simultaneous dequeue: queue at 16, rdy pulsed in the same cycle as the 17th write's enqueue -> no drop, count stays 16, ovf_out=0.
- DDS routing (N_DDS=2, N_DAC=8): channels 8, 11, 13 -> DDS0 freq (sel 00); DDS1 phase (sel 01); DDS1 amp (sel 10). With dds_rdy_in=2'b01, DDS0 drains while DDS1 holds vld with 2 entries and the DAC queue is unaffected.
- Unmapped/saturation (W_CNT=2): 5 writes to channel 31 -> no vld on any output, drop_cnt=3. clr_in asserted in the same cycle as a 6th drop -> drop_cnt=0.
- Async reset: assert rst_in low mid-cycle with 5 queued DAC entries and vld high -> vld and data go to 0 before the next edge. After release, the next write appears at t+2 with no stale entries.
